bullet_pool: RTL and testbench

- Parametrised successor to the fixed four-bullet manager: owns a pool of N_BULLETS projectiles, allocates a free slot on fire, moves every active bullet one step per frame, and retires bullets that go off-screen or are hit.
- Adds synchronous fire-edge detection, a fire cooldown, hit kills, and accept/drop status pulses.
- Sits between the ship/input logic and the collision/VGA mixer; its per-slot pixel outputs feed the collision detector, which returns per-slot hit.

---
 rtl/bullet_pool.sv | 187 ++++++++++++++++++
 tb/tb_bullet_pool.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_pool.sv
// Purpose : pool of N_BULLETS projectiles; allocates on fire, steps each active
//           bullet once per frame, retires off-screen or hit bullets.
// Latency : fire, movement and retirement take effect on the next clk edge;
//           o_pixel / o_active_count are combinational from registered state.
// Backpressure: none; a fire request that cannot be accepted is dropped
//           (o_fire_drop pulse), never queued.
//
// Ports:
//   i_clk_60hz      frame clock, one rising edge per frame
//   i_reset         asynchronous, active-high
//   i_px, i_py      current VGA pixel coordinate
//   i_ship_x        ship left edge, used to centre the launch x
//   i_shoot_up/down level fire buttons, synchronous to i_clk_60hz
//   i_hit           per-slot kill request from collision logic
//   o_pixel         per-slot "bullet covers (px,py)"
//   o_in_use        per-slot active flag
//   o_active_count  number of active slots
//   o_fire_ack      one-frame pulse: fire accepted
//   o_fire_drop     one-frame pulse: fire rejected
//
// Optional build macro: BULLET_POOL_AUTOFIRE_EN
//   defined   -> a held button refires whenever the cooldown has expired
//   undefined -> firing only on a button rising edge

module bullet_pool #(
    parameter int N_BULLETS    = 4,
    parameter int SPEED        = 4,
    parameter int BULLET_W     = 2,
    parameter int BULLET_H     = 8,
    parameter int SHIP_W       = 16,
    parameter int Y_UP_START   = 432,
    parameter int Y_DOWN_START = 40,
    parameter int SCREEN_H     = 480,
    parameter int COOLDOWN     = 3
) (
    input  logic                 i_clk_60hz,
    input  logic                 i_reset,
    input  logic [9:0]           i_px,
    input  logic [9:0]           i_py,
    input  logic [9:0]           i_ship_x,
    input  logic                 i_shoot_up,
    input  logic                 i_shoot_down,
    input  logic [N_BULLETS-1:0] i_hit,
    output logic [N_BULLETS-1:0] o_pixel,
    output logic [N_BULLETS-1:0] o_in_use,
    output logic [3:0]           o_active_count,
    output logic                 o_fire_ack,
    output logic                 o_fire_drop
);

    localparam int IDX_W = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1;
    localparam int CD_W  = (COOLDOWN > 1) ? $clog2(COOLDOWN + 1) : 1;

    localparam logic [10:0] L_SPEED = 11'(SPEED);
    localparam logic [10:0] L_BW    = 11'(BULLET_W);
    localparam logic [10:0] L_BH    = 11'(BULLET_H);
    // Last y at which a downward bullet still fits fully on screen.
    localparam logic [10:0] L_LIMIT = 11'(SCREEN_H - BULLET_H);

    // Slot state. r_dir: 0 = moving up, 1 = moving down.
    logic [N_BULLETS-1:0] r_in_use;
    logic [9:0]           r_x   [N_BULLETS];
    logic [9:0]           r_y   [N_BULLETS];
    logic                 r_dir [N_BULLETS];
    logic [CD_W-1:0]      r_cooldown;
    logic                 r_shoot_prev;
    logic                 r_fire_ack;
    logic                 r_fire_drop;

    logic                 w_any_btn;
    logic                 w_req;
    logic                 w_free_any;
    logic [IDX_W-1:0]     w_free_idx;
    logic                 w_accept;
    logic [9:0]           w_launch_x;
    logic [10:0]          w_px11;
    logic [10:0]          w_py11;
    logic [3:0]           w_count;

    assign w_any_btn = i_shoot_up | i_shoot_down;

`ifdef BULLET_POOL_AUTOFIRE_EN
    // Held button keeps requesting once the cooldown has run out.
    assign w_req = w_any_btn & (~r_shoot_prev | (r_cooldown == '0));
`else
    assign w_req = w_any_btn & ~r_shoot_prev;
`endif

    // Free-slot search uses in_use as it stood at the start of the frame,
    // so a slot retiring this frame is only reusable on the next one.
    assign w_free_any = ~&r_in_use;

    always_comb begin
        w_free_idx = '0;
        for (int i = N_BULLETS - 1; i >= 0; i--) begin
            if (!r_in_use[i]) begin
                w_free_idx = IDX_W'(i);
            end
        end
    end

    assign w_accept = w_req & (r_cooldown == '0) & w_free_any;

    // Centred launch x; modulo-1024 wrap matches an 11-bit sum truncated to 10.
    assign w_launch_x = i_ship_x + 10'(SHIP_W / 2 - BULLET_W / 2);

    always_ff @(posedge i_clk_60hz or posedge i_reset) begin
        if (i_reset) begin
            r_in_use     <= '0;
            r_cooldown   <= '0;
            r_shoot_prev <= 1'b1;  // a button held through reset must not fire
            r_fire_ack   <= 1'b0;
            r_fire_drop  <= 1'b0;
            for (int i = 0; i < N_BULLETS; i++) begin
                r_x[i]   <= '0;
                r_y[i]   <= '0;
                r_dir[i] <= 1'b0;
            end
        end else begin
            r_shoot_prev <= w_any_btn;
            r_fire_ack   <= w_accept;
            r_fire_drop  <= w_req & ~w_accept;

            if (w_accept) begin
                r_cooldown <= CD_W'(COOLDOWN);
            end else if (r_cooldown != '0) begin
                r_cooldown <= r_cooldown - CD_W'(1);
            end

            // Movement / retirement; hit beats the off-screen checks.
            for (int i = 0; i < N_BULLETS; i++) begin
                if (r_in_use[i]) begin
                    if (i_hit[i]) begin
                        r_in_use[i] <= 1'b0;
                    end else if (!r_dir[i]) begin
                        if ({1'b0, r_y[i]} < L_SPEED) begin
                            r_in_use[i] <= 1'b0;
                        end else begin
                            r_y[i] <= r_y[i] - L_SPEED[9:0];
                        end
                    end else begin
                        if (({1'b0, r_y[i]} + L_SPEED) > L_LIMIT) begin
                            r_in_use[i] <= 1'b0;
                        end else begin
                            r_y[i] <= r_y[i] + L_SPEED[9:0];
                        end
                    end
                end
            end

            // The allocated slot was inactive, so the loop above never
            // touches it: launch wins over any hit and it does not move yet.
            if (w_accept) begin
                r_in_use[w_free_idx] <= 1'b1;
                r_x[w_free_idx]      <= w_launch_x;
                r_y[w_free_idx]      <= i_shoot_up ? 10'(Y_UP_START) : 10'(Y_DOWN_START);
                r_dir[w_free_idx]    <= ~i_shoot_up;  // both buttons -> up
            end
        end
    end

    // Coverage test with 11-bit sums so a bullet near x=1023 does not wrap.
    assign w_px11 = {1'b0, i_px};
    assign w_py11 = {1'b0, i_py};

    always_comb begin
        o_pixel = '0;
        for (int i = 0; i < N_BULLETS; i++) begin
            o_pixel[i] = r_in_use[i]
                       & (w_px11 >= {1'b0, r_x[i]}) & (w_px11 < ({1'b0, r_x[i]} + L_BW))
                       & (w_py11 >= {1'b0, r_y[i]}) & (w_py11 < ({1'b0, r_y[i]} + L_BH));
        end
    end

    always_comb begin
        w_count = '0;
        for (int i = 0; i < N_BULLETS; i++) begin
            w_count = w_count + 4'(r_in_use[i]);
        end
    end

    assign o_in_use       = r_in_use;
    assign o_active_count = w_count;
    assign o_fire_ack     = r_fire_ack;
    assign o_fire_drop    = r_fire_drop;

endmodule

// File: tb/tb_bullet_pool.sv
// Purpose : randomized + directed bench for bullet_pool with a queue scoreboard.
// Latency : expectation for each frame is queued at the negedge before the edge
//           and popped by the monitor just after that edge.
// Backpressure: n/a.

module tb_bullet_pool;

    localparam int N     = 4;
    localparam int SPEED = 4;
    localparam int BW    = 2;
    localparam int BH    = 8;
    localparam int SHIPW = 16;
    localparam int YUP   = 432;
    localparam int YDN   = 40;
    localparam int SH    = 480;
    localparam int CD    = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [9:0]   px, py, ship_x;
    logic         up, dn;
    logic [N-1:0] hit;
    logic [N-1:0] pixel, in_use;
    logic [3:0]   cnt;
    logic         ack, drop;

    bullet_pool dut (
        .i_clk_60hz    (clk),
        .i_reset       (rst),
        .i_px          (px),
        .i_py          (py),
        .i_ship_x      (ship_x),
        .i_shoot_up    (up),
        .i_shoot_down  (dn),
        .i_hit         (hit),
        .o_pixel       (pixel),
        .o_in_use      (in_use),
        .o_active_count(cnt),
        .o_fire_ack    (ack),
        .o_fire_drop   (drop)
    );

    always #100 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]       use_v;
        logic               ack;
        logic               drop;
        logic [N-1:0][9:0]  xs;
        logic [N-1:0][9:0]  ys;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: plain per-bullet records.
    bit m_act [N];
    int m_x   [N];
    int m_y   [N];
    bit m_down[N];
    int m_cd;
    bit m_prev;
    bit m_ack, m_drop;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_down[i] = 0;
        end
        m_cd = 0; m_prev = 1; m_ack = 0; m_drop = 0;
    endfunction

    function automatic void model_frame(input bit u, input bit d, input logic [N-1:0] h, input int sx);
        bit req, acc;
        int fr;
`ifdef BULLET_POOL_AUTOFIRE_EN
        req = (u || d) && (!m_prev || m_cd == 0);
`else
        req = (u || d) && !m_prev;
`endif
        fr = -1;
        for (int i = 0; i < N; i++) if (!m_act[i] && fr < 0) fr = i;
        acc = req && (m_cd == 0) && (fr >= 0);
        for (int i = 0; i < N; i++) begin
            if (m_act[i]) begin
                if (h[i]) m_act[i] = 0;
                else if (!m_down[i]) begin
                    if (m_y[i] < SPEED) m_act[i] = 0; else m_y[i] -= SPEED;
                end else begin
                    if (m_y[i] + SPEED > SH - BH) m_act[i] = 0; else m_y[i] += SPEED;
                end
            end
        end
        if (acc) begin
            m_act[fr]  = 1;
            m_x[fr]    = (sx + SHIPW / 2 - BW / 2) % 1024;
            m_y[fr]    = u ? YUP : YDN;
            m_down[fr] = !u;
        end
        m_ack  = acc;
        m_drop = req && !acc;
        m_cd   = acc ? CD : ((m_cd > 0) ? m_cd - 1 : 0);
        m_prev = u || d;
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        e.ack  = m_ack;
        e.drop = m_drop;
        for (int i = 0; i < N; i++) begin
            e.use_v[i] = m_act[i];
            e.xs[i]    = 10'(m_x[i]);
            e.ys[i]    = 10'(m_y[i]);
        end
        return e;
    endfunction

    // One frame of stimulus, applied at the negedge before the active edge.
    task automatic frame(input bit r, input bit u, input bit d, input logic [N-1:0] h, input int sx);
        @(negedge clk);
        rst = r; up = u; dn = d; hit = h; ship_x = 10'(sx);
        if (r) begin
            #1;
            chk("rst_in_use", 32'(in_use), 0);
            chk("rst_count",  32'(cnt),    0);
            chk("rst_ack",    32'(ack),    0);
            chk("rst_drop",   32'(drop),   0);
            chk("rst_pixel",  32'(pixel),  0);
            model_reset();
        end else begin
            model_frame(u, d, h, sx);
        end
        sbq.push_back(snapshot());
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) frame(0, 0, 0, '0, 100);
    endtask

    // Monitor: pops one expectation per active edge and probes pixel coverage
    // around every expected live bullet.
    initial begin
        exp_t e;
        int   ec, pxv, pyv;
        int   dxs [6] = '{0, 1, BW, 0, -1, 0};
        int   dys [6] = '{0, BH - 1, 0, BH, 0, -1};
        logic [N-1:0] ev;
        px = '0; py = '0;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                ec = 0;
                for (int i = 0; i < N; i++) ec += int'(e.use_v[i]);
                chk("in_use",       32'(in_use), 32'(e.use_v));
                chk("active_count", 32'(cnt),    32'(ec));
                chk("fire_ack",     32'(ack),    32'(e.ack));
                chk("fire_drop",    32'(drop),   32'(e.drop));
                for (int i = 0; i < N; i++) begin
                    if (e.use_v[i]) begin
                        for (int p = 0; p < 6; p++) begin
                            pxv = int'(e.xs[i]) + dxs[p];
                            pyv = int'(e.ys[i]) + dys[p];
                            if (pxv >= 0 && pxv <= 1023 && pyv >= 0 && pyv <= 1023) begin
                                px = 10'(pxv); py = 10'(pyv);
                                #1;
                                for (int j = 0; j < N; j++)
                                    ev[j] = e.use_v[j]
                                          && pxv >= int'(e.xs[j]) && pxv < int'(e.xs[j]) + BW
                                          && pyv >= int'(e.ys[j]) && pyv < int'(e.ys[j]) + BH;
                                chk("pixel", 32'(pixel), 32'(ev));
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; up = 1'b1; dn = 1'b0; hit = '0; ship_x = 10'd100;
        model_reset();

        // Button held through reset and after release: no fire.
        frame(1, 1, 0, '0, 100);
        frame(1, 1, 0, '0, 100);
        for (int k = 0; k < 3; k++) frame(0, 1, 0, '0, 100);
        frame(0, 0, 0, '0, 100);

        // Single upward bullet from ship_x=100 -> x=107, y=432, retires at k=109.
        frame(0, 1, 0, '0, 100);
        idle(112);

        // Cooldown: edges at t, t+2, t+4 -> accept, drop, accept (slot1).
        frame(0, 1, 0, '0, 100);
        idle(1);
        frame(0, 1, 0, '0, 100);
        idle(1);
        frame(0, 1, 0, '0, 100);
        idle(4);

        // Fill the pool, fifth edge dropped, hit slot2, refire reuses slot2.
        frame(0, 1, 0, '0, 200); idle(4);
        frame(0, 1, 0, '0, 300); idle(4);
        frame(0, 1, 0, '0, 400);
        idle(1);
        frame(0, 0, 0, 4'b0100, 100);
        idle(4);
        frame(0, 1, 0, '0, 500);
        idle(120);

        // Downward shot, killed mid-flight by a hit.
        frame(0, 0, 1, '0, 300);
        idle(20);
        frame(0, 0, 0, 4'b0001, 100);
        idle(4);
        // Downward shot running to the bottom (y=472 retires).
        frame(0, 0, 1, '0, 1020);
        idle(112);
        // Both buttons -> upward.
        frame(0, 1, 1, '0, 50);
        idle(5);

        // Randomized phase.
        for (int k = 0; k < 400; k++) begin
            frame(0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  ($urandom_range(0, 9) == 0) ? N'($urandom) : '0,
                  int'($urandom_range(0, 1023)));
        end
        idle(4);

        // Reset mid-flight clears everything asynchronously.
        frame(0, 1, 0, '0, 100);
        idle(5);
        frame(1, 0, 0, '0, 100);
        frame(0, 0, 0, '0, 100);
        frame(0, 1, 0, '0, 100);
        idle(3);

        @(posedge clk);
        #50;
        chk("scoreboard_drained", 32'(sbq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
